// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: serialises trap entry and mret CSR updates over one
// write port, holds the pipeline while active, then issues a single PC redirect.
module trap_sequencer #(
    parameter int         XLEN       = 64,
    parameter logic [1:0] RESET_PRIV = 2'b11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            except_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic [XLEN-1:0] ecause_i,
    input  logic [XLEN-1:0] etval_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            csr_we_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            flush_o,
    output logic            stall_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [1:0]      priv_o,
    output logic            busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_TVAL,
        T_STAT,
        R_STAT,
        REDIR
    } state_t;

    state_t          state;
    logic [XLEN-1:0] lat_pc;
    logic [XLEN-1:0] lat_cause;
    logic [XLEN-1:0] lat_tval;
    logic [XLEN-1:0] lat_mstatus;
    logic [XLEN-1:0] lat_mtvec;
    logic [1:0]      lat_priv;
    logic            lat_mret;

    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] trap_status;
    logic [XLEN-1:0] ret_status;

    // The cause MSB is the interrupt flag, so it drops out of the vector offset.
    logic unused_bits;
    assign unused_bits = ^{epc_i[1:0], mepc_i[1:0], lat_cause[XLEN-2]};

    always_comb begin
        vec_base    = {lat_mtvec[XLEN-1:2], 2'b00};
        trap_target = vec_base;
        if (lat_mtvec[1:0] == 2'b01 && lat_cause[XLEN-1])
            trap_target = vec_base + {lat_cause[XLEN-3:0], 2'b00};

        trap_status        = lat_mstatus;
        trap_status[7]     = lat_mstatus[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = lat_priv;

        // The mret status write is issued straight from IDLE, so it uses the live mstatus.
        ret_status         = mstatus_i;
        ret_status[3]      = mstatus_i[7];
        ret_status[7]      = 1'b1;
        ret_status[12:11]  = 2'b00;
    end

    assign busy_o  = (state != IDLE);
    assign flush_o = busy_o;
    assign stall_o = busy_o;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            priv_o        <= RESET_PRIV;
            csr_we_o      <= 1'b0;
            csr_waddr_o   <= '0;
            csr_wdata_o   <= '0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            lat_pc        <= '0;
            lat_cause     <= '0;
            lat_tval      <= '0;
            lat_mstatus   <= '0;
            lat_mtvec     <= '0;
            lat_priv      <= '0;
            lat_mret      <= 1'b0;
        end else begin
            csr_we_o      <= 1'b0;
            csr_waddr_o   <= '0;
            csr_wdata_o   <= '0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            case (state)
                IDLE: begin
                    if (except_i) begin
                        lat_pc      <= {epc_i[XLEN-1:2], 2'b00};
                        lat_cause   <= ecause_i;
                        lat_tval    <= etval_i;
                        lat_mstatus <= mstatus_i;
                        lat_mtvec   <= mtvec_i;
                        lat_priv    <= priv_o;
                        lat_mret    <= 1'b0;
                        csr_we_o    <= 1'b1;
                        csr_waddr_o <= 12'h341;
                        csr_wdata_o <= {epc_i[XLEN-1:2], 2'b00};
                        state       <= T_EPC;
                    end else if (mret_i) begin
                        lat_mstatus <= mstatus_i;
                        lat_pc      <= {mepc_i[XLEN-1:2], 2'b00};
                        lat_mret    <= 1'b1;
                        csr_we_o    <= 1'b1;
                        csr_waddr_o <= 12'h300;
                        csr_wdata_o <= ret_status;
                        state       <= R_STAT;
                    end
                end
                T_EPC: begin
                    csr_we_o    <= 1'b1;
                    csr_waddr_o <= 12'h342;
                    csr_wdata_o <= lat_cause;
                    state       <= T_CAUSE;
                end
                T_CAUSE: begin
                    csr_we_o    <= 1'b1;
                    csr_waddr_o <= 12'h343;
                    csr_wdata_o <= lat_tval;
                    state       <= T_TVAL;
                end
                T_TVAL: begin
                    csr_we_o    <= 1'b1;
                    csr_waddr_o <= 12'h300;
                    csr_wdata_o <= trap_status;
                    state       <= T_STAT;
                end
                T_STAT: begin
                    redirect_o    <= 1'b1;
                    redirect_pc_o <= trap_target;
                    state         <= REDIR;
                end
                R_STAT: begin
                    redirect_o    <= 1'b1;
                    redirect_pc_o <= lat_pc;
                    state         <= REDIR;
                end
                REDIR: begin
                    priv_o <= lat_mret ? lat_mstatus[12:11] : 2'b11;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: expected CSR writes and redirects are queued
// when a trigger is driven and matched against DUT events as they appear.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        except_i = 1'b0;
    logic [63:0] epc_i = '0;
    logic [63:0] ecause_i = '0;
    logic [63:0] etval_i = '0;
    logic        mret_i = 1'b0;
    logic [63:0] mstatus_i = '0;
    logic [63:0] mtvec_i = '0;
    logic [63:0] mepc_i = '0;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [63:0] csr_wdata_o;
    logic        flush_o;
    logic        stall_o;
    logic        redirect_o;
    logic [63:0] redirect_pc_o;
    logic [1:0]  priv_o;
    logic        busy_o;

    typedef struct {
        bit          is_redir;
        logic [11:0] addr;
        logic [63:0] data;
        int          cyc;
    } event_t;

    event_t     sb[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] tb_priv = 2'b11;
    int         p;

    trap_sequencer #(.XLEN(64), .RESET_PRIV(2'b11)) dut (
        .clk(clk), .rst(rst), .except_i(except_i), .epc_i(epc_i), .ecause_i(ecause_i),
        .etval_i(etval_i), .mret_i(mret_i), .mstatus_i(mstatus_i), .mtvec_i(mtvec_i),
        .mepc_i(mepc_i), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .flush_o(flush_o), .stall_o(stall_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .priv_o(priv_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every CSR write or redirect the DUT produces must match the next queued expectation.
    always @(negedge clk) begin
        event_t e;
        if (csr_we_o || redirect_o) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_event", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("event_kind", {63'd0, redirect_o}, {63'd0, e.is_redir});
                if (e.is_redir) begin
                    checkOutput("redirect_pc", redirect_pc_o, e.data);
                end else begin
                    checkOutput("csr_addr", {52'd0, csr_waddr_o}, {52'd0, e.addr});
                    checkOutput("csr_data", csr_wdata_o, e.data);
                end
                checkOutput("event_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (busy_o) begin
            checkOutput("quiet_waddr", {52'd0, csr_waddr_o}, 64'd0);
            checkOutput("quiet_wdata", csr_wdata_o, 64'd0);
        end
    end

    function automatic void pushEvent(bit r, logic [11:0] a, logic [63:0] d, int c);
        event_t e;
        e.is_redir = r;
        e.addr     = a;
        e.data     = d;
        e.cyc      = c;
        sb.push_back(e);
    endfunction

    // Drives one trigger cycle and queues the sequence the DUT should produce for it.
    task automatic applyStimulus(input logic exc, input logic mr, input logic [63:0] epc,
                                 input logic [63:0] cause, input logic [63:0] tval,
                                 input logic [63:0] mst, input logic [63:0] mtvec,
                                 input logic [63:0] mepc, output int pt);
        logic [63:0] base;
        logic [63:0] target;
        logic [63:0] st;
        @(posedge clk); #1;
        except_i = exc; mret_i = mr; epc_i = epc; ecause_i = cause; etval_i = tval;
        mstatus_i = mst; mtvec_i = mtvec; mepc_i = mepc;
        pt = cyc + 1;
        if (exc) begin
            base   = mtvec & ~64'h3;
            target = (mtvec[1:0] == 2'b01 && cause[63]) ? base + (cause & ~(64'h1 << 63)) * 4 : base;
            st     = (mst & ~64'h1888) | (mst[3] ? 64'h80 : 64'h0) | ({62'd0, tb_priv} << 11);
            pushEvent(0, 12'h341, epc & ~64'h3, pt);
            pushEvent(0, 12'h342, cause, pt + 1);
            pushEvent(0, 12'h343, tval, pt + 2);
            pushEvent(0, 12'h300, st, pt + 3);
            pushEvent(1, 12'h000, target, pt + 4);
            tb_priv = 2'b11;
        end else if (mr) begin
            st = (mst & ~64'h1888) | 64'h80 | (mst[7] ? 64'h8 : 64'h0);
            pushEvent(0, 12'h300, st, pt);
            pushEvent(1, 12'h000, mepc & ~64'h3, pt + 1);
            tb_priv = mst[12:11];
        end
        @(posedge clk); #1;
        except_i = 1'b0; mret_i = 1'b0;
    endtask

    task automatic checkSequence(input int len);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            checkOutput("busy_active", {63'd0, busy_o}, 64'd1);
            checkOutput("flush_active", {63'd0, flush_o}, 64'd1);
            checkOutput("stall_active", {63'd0, stall_o}, 64'd1);
        end
        @(negedge clk);
        checkOutput("busy_done", {63'd0, busy_o}, 64'd0);
        checkOutput("flush_done", {63'd0, flush_o}, 64'd0);
        checkOutput("priv_after", {62'd0, priv_o}, {62'd0, tb_priv});
        checkOutput("queue_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_we"}, {63'd0, csr_we_o}, 64'd0);
        checkOutput({tag, "_waddr"}, {52'd0, csr_waddr_o}, 64'd0);
        checkOutput({tag, "_wdata"}, csr_wdata_o, 64'd0);
        checkOutput({tag, "_flush"}, {63'd0, flush_o}, 64'd0);
        checkOutput({tag, "_stall"}, {63'd0, stall_o}, 64'd0);
        checkOutput({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
        checkOutput({tag, "_redirect"}, {63'd0, redirect_o}, 64'd0);
        checkOutput({tag, "_redirect_pc"}, redirect_pc_o, 64'd0);
        checkOutput({tag, "_priv"}, {62'd0, priv_o}, 64'd3);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b1;

        // Illegal instruction from M-mode
        applyStimulus(1, 0, 64'h8000_0104, 64'd2, 64'h73, 64'h8, 64'h8000_0000, 64'h0, p);
        checkSequence(5);

        // Vectored interrupt
        applyStimulus(1, 0, 64'h8000_0300, 64'h8000_0000_0000_0007, 64'h0, 64'h8,
                      64'h8000_1001, 64'h0, p);
        checkSequence(5);

        // mret back to user mode
        applyStimulus(0, 1, 64'h0, 64'h0, 64'h0, 64'h80, 64'h0, 64'h8000_0200, p);
        checkSequence(2);

        // User-mode ecall with misaligned epc low bits
        applyStimulus(1, 0, 64'h8000_0106, 64'd8, 64'h0, 64'h88, 64'h8000_0000, 64'h0, p);
        checkSequence(5);

        // Simultaneous except/mret, mode 11 treated as direct, retrigger during T_CAUSE
        fork
            begin
                applyStimulus(1, 1, 64'h8000_0500, 64'h8000_0000_0000_0003, 64'h55, 64'h0,
                              64'h8000_3003, 64'h9000_0000, p);
                checkSequence(5);
            end
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                except_i = 1'b1; epc_i = 64'h1234; ecause_i = 64'd5;
                @(posedge clk); #1;
                except_i = 1'b0;
            end
        join

        // mret to M-mode with mepc low bits set
        applyStimulus(0, 1, 64'h0, 64'h0, 64'h0, 64'h1800, 64'h0, 64'h8000_0406, p);
        checkSequence(2);

        // Reset asserted during T_TVAL
        applyStimulus(1, 0, 64'h8000_0700, 64'd4, 64'h99, 64'h8, 64'h8000_0000, 64'h0, p);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        tb_priv = 2'b11;
        checkResetState("midreset");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("no_redirect_after_reset", {63'd0, redirect_o}, 64'd0);
        end

        // Recovery after reset
        applyStimulus(1, 0, 64'h8000_0104, 64'd2, 64'h73, 64'h8, 64'h8000_0000, 64'h0, p);
        checkSequence(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
